// File: rtl/intr_vector_ctrl_pkg.sv
// Shared constants for the interrupt vector controller: FSM states, code offsets,
// default word width and default vector-table stride.
package intr_vector_ctrl_pkg;

  localparam int WORD_BITS_DEFAULT   = 32;
  localparam int DEFAULT_STRIDE_LOG2 = 4;
  localparam int HARD_BASE           = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } intr_state_e;

  // Soft codes start right after the last hard code; code 0 means "none".
  function automatic int soft_base(input int n_hard);
    return n_hard + HARD_BASE;
  endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Find-first-set priority encoder: the lowest set bit wins, valid flags any set bit.
module intr_prio_enc #(
  parameter int WIDTH    = 12,
  parameter int IDX_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]    req,
  output logic                valid,
  output logic [IDX_BITS-1:0] index
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = IDX_BITS'(i);
      end
    end
  end

endmodule

// File: rtl/intr_vector_ctrl.sv
// Interrupt/exception vector controller: latches hard IRQs and soft exceptions, arbitrates by
// fixed priority and holds the vector under req/ack until eret. Define INTR_EDGE_DETECT_EN for edge-latched hard IRQs.
module intr_vector_ctrl
  import intr_vector_ctrl_pkg::*;
#(
  parameter int WORD_BITS       = WORD_BITS_DEFAULT,
  parameter int N_HARD          = 8,
  parameter int N_SOFT          = 4,
  parameter int VEC_STRIDE_LOG2 = DEFAULT_STRIDE_LOG2,
  parameter int CODE_BITS       = $clog2(N_HARD + N_SOFT + 1),
  parameter int SIDX_BITS       = (N_SOFT > 1) ? $clog2(N_SOFT) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [N_HARD-1:0]          i_h_irq,
  input  logic                       i_s_valid,
  input  logic [SIDX_BITS-1:0]       i_s_idx,
  input  logic                       i_mask_we,
  input  logic [N_HARD-1:0]          i_mask_wdata,
  input  logic [WORD_BITS-1:0]       i_vec_base,
  input  logic                       i_intr_ack,
  input  logic                       i_eret,
  output logic                       o_intr_req,
  output logic [WORD_BITS-1:0]       o_intr_address,
  output logic [CODE_BITS-1:0]       o_intr_code,
  output logic                       o_in_service,
  output logic [N_HARD+N_SOFT-1:0]   o_pending
);

  localparam int N_ALL    = N_HARD + N_SOFT;
  localparam int IDX_BITS = (N_ALL > 1) ? $clog2(N_ALL) : 1;

  intr_state_e            state_q, state_d;
  logic [N_HARD-1:0]      mask_q;
  logic [N_HARD-1:0]      hard_pend;
  logic [N_SOFT-1:0]      soft_pend_q;
  logic [N_SOFT-1:0]      set_soft, clr_soft;
  logic [CODE_BITS-1:0]   code_q;
  logic [WORD_BITS-1:0]   addr_q;
  logic                   take, ack_take;
  logic                   win_valid;
  logic [IDX_BITS-1:0]    win_idx;
  logic [CODE_BITS-1:0]   win_code;
  logic [WORD_BITS-1:0]   win_addr;

  // Hard bits sit in the LSBs so any eligible hard source beats every soft one.
  intr_prio_enc #(
    .WIDTH    (N_ALL),
    .IDX_BITS (IDX_BITS)
  ) u_prio (
    .req   ({soft_pend_q, hard_pend & mask_q}),
    .valid (win_valid),
    .index (win_idx)
  );

  assign win_code = CODE_BITS'(win_idx) + CODE_BITS'(HARD_BASE);
  assign win_addr = i_vec_base + (WORD_BITS'(win_code) << VEC_STRIDE_LOG2);

  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    ack_take = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = ST_REQ;
          take    = 1'b1;
        end
      end
      ST_REQ: begin
        if (i_intr_ack) begin
          state_d  = ST_SERVICE;
          ack_take = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (i_eret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // An out-of-range index shifts the single bit off the top, so it sets nothing.
  always_comb begin
    set_soft = '0;
    clr_soft = '0;
    if (i_s_valid) set_soft = N_SOFT'(1) << i_s_idx;
    if (ack_take && (code_q >= CODE_BITS'(soft_base(N_HARD))))
      clr_soft = N_SOFT'(1) << (code_q - CODE_BITS'(soft_base(N_HARD)));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      soft_pend_q <= '0;
      code_q      <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      soft_pend_q <= (soft_pend_q & ~clr_soft) | set_soft;
      if (i_mask_we) mask_q <= i_mask_wdata;
      if (take) begin
        code_q <= win_code;
        addr_q <= win_addr;
      end
    end
  end

`ifdef INTR_EDGE_DETECT_EN
  logic [N_HARD-1:0] irq_q;
  logic [N_HARD-1:0] hard_pend_q;
  logic [N_HARD-1:0] clr_hard;

  always_comb begin
    clr_hard = '0;
    if (ack_take && (code_q < CODE_BITS'(soft_base(N_HARD))))
      clr_hard = N_HARD'(1) << (code_q - CODE_BITS'(HARD_BASE));
  end

  // A fresh rising edge in the same cycle as the ack keeps the bit pending.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      irq_q       <= '0;
      hard_pend_q <= '0;
    end else begin
      irq_q       <= i_h_irq;
      hard_pend_q <= (hard_pend_q & ~clr_hard) | (i_h_irq & ~irq_q);
    end
  end

  assign hard_pend = hard_pend_q;
`else
  assign hard_pend = i_h_irq;
`endif

  assign o_intr_req     = (state_q == ST_REQ);
  assign o_in_service   = (state_q == ST_SERVICE);
  assign o_intr_address = addr_q;
  assign o_intr_code    = code_q;
  assign o_pending      = {soft_pend_q, hard_pend};

endmodule
